// File: rtl/sr_display_receiver.sv
// sr_display_receiver: rebuilds the value shown by a 74HC595-style 7-segment chain.
//   It samples the data, shift-clock and latch lines asynchronously, deserialises one
//   NUM_7_SEG_DISPLAYS*8-bit frame per latch pulse and decodes each byte back to a hex digit.
// Ports: clk/rst (async active-high); i_sr_data/i_sr_clk/i_sr_latch serial lines;
//   o_data/o_data_is_neg/o_error with o_valid, accepted by i_ready.
// Latency: latch first sampled at edge N -> o_valid after N+4 (N+5 with the glitch filter).
//   o_valid holds until accepted. The shifter never stalls, and a newer latch overwrites a pending frame.
// Optional: define SR_RX_GLITCH_FILTER_EN for a 2-sample agreement filter on each input.
module sr_display_receiver #(
  parameter int DATA_WIDTH         = 16,
  parameter int NUM_7_SEG_DISPLAYS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sr_data,
  input  logic                  i_sr_clk,
  input  logic                  i_sr_latch,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_is_neg,
  output logic                  o_error,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int FRAME_BITS = NUM_7_SEG_DISPLAYS * 8;
  localparam int DIG_BITS   = NUM_7_SEG_DISPLAYS * 4;

  typedef enum logic [1:0] {IDLE, DECODE, PRESENT} state_t;

  // Bit 0 = data, bit 1 = shift clock, bit 2 = latch.
  logic [2:0] sync1_q, sync2_q, hist_q, line_s;

`ifdef SR_RX_GLITCH_FILTER_EN
  logic [2:0] filt_q, filt_d;
  // sync1/sync2 hold two consecutive samples, so the filtered value follows only when they agree.
  assign filt_d = (~(sync1_q ^ sync2_q) & sync2_q) | ((sync1_q ^ sync2_q) & filt_q);
  assign line_s = filt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_q <= '0;
    else     filt_q <= filt_d;
  end
`else
  assign line_s = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= {i_sr_latch, i_sr_clk, i_sr_data};
      sync2_q <= sync1_q;
      hist_q  <= line_s;
    end
  end

  logic sr_clk_rise, latch_rise;
  assign sr_clk_rise = line_s[1] & ~hist_q[1];
  assign latch_rise  = line_s[2] & ~hist_q[2];

  // Shift register and bit counter run in every FSM state.
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [7:0]            cnt_q, cnt_d, cnt_shift;

  always_comb begin
    shift_d   = shift_q;
    cnt_shift = cnt_q;
    if (sr_clk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], line_s[0]};
      if (cnt_q != 8'hFF) cnt_shift = cnt_q + 8'd1;
    end
    cnt_d = latch_rise ? 8'd0 : cnt_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Snapshot takes post-shift contents so a same-cycle clock rise belongs to the latched frame.
  logic [FRAME_BITS-1:0] frame_q;
  logic [7:0]            fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      fcnt_q  <= '0;
    end else if (latch_rise) begin
      frame_q <= shift_d;
      fcnt_q  <= cnt_shift;
    end
  end

  // Returns {unknown, minus, digit[3:0]}; dp (bit 7) is ignored by the caller.
  function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b000000;
    case (seg)
      7'h3F: r[3:0] = 4'h0;
      7'h06: r[3:0] = 4'h1;
      7'h5B: r[3:0] = 4'h2;
      7'h4F: r[3:0] = 4'h3;
      7'h66: r[3:0] = 4'h4;
      7'h6D: r[3:0] = 4'h5;
      7'h7D: r[3:0] = 4'h6;
      7'h07: r[3:0] = 4'h7;
      7'h7F: r[3:0] = 4'h8;
      7'h6F: r[3:0] = 4'h9;
      7'h77: r[3:0] = 4'hA;
      7'h7C: r[3:0] = 4'hB;
      7'h39: r[3:0] = 4'hC;
      7'h5E: r[3:0] = 4'hD;
      7'h79: r[3:0] = 4'hE;
      7'h71: r[3:0] = 4'hF;
      7'h00: r[3:0] = 4'h0;   // blank = suppressed leading zero
      7'h40: r[4]   = 1'b1;   // minus
      default: r[5] = 1'b1;
    endcase
    return r;
  endfunction

  logic [DIG_BITS-1:0]            dig_all;
  logic [DIG_BITS+DATA_WIDTH-1:0] dig_ext;
  logic [DATA_WIDTH-1:0]          data_d;
  logic                           neg_d, err_d, bad_any;
  logic [7:0]                     minus_cnt;
  logic [5:0]                     g;

  always_comb begin
    dig_all   = '0;
    bad_any   = 1'b0;
    minus_cnt = '0;
    g         = '0;
    for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
      g                = decode_glyph(frame_q[8*k +: 7]);
      dig_all[4*k +: 4] = g[3:0];
      minus_cnt        = minus_cnt + {7'd0, g[4]};
      bad_any          = bad_any | g[5];
    end
    // Zero-extend then truncate so any DATA_WIDTH relative to the digit count works.
    dig_ext = {{DATA_WIDTH{1'b0}}, dig_all};
    data_d  = dig_ext[DATA_WIDTH-1:0];
    neg_d   = (minus_cnt != 8'd0);
    err_d   = bad_any | (minus_cnt >= 8'd2) | (fcnt_q != 8'(FRAME_BITS));
  end

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (latch_rise) state_d = DECODE;
      DECODE:  state_d = latch_rise ? DECODE : PRESENT;
      PRESENT: begin
        if (latch_rise)                state_d = DECODE;
        else if (o_valid && i_ready)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // o_valid rises one cycle into PRESENT; it drops on acceptance or when a newer frame overwrites.
  logic valid_d;
  assign valid_d = (state_q == PRESENT) && (state_d == PRESENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_data_is_neg <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state_q <= state_d;
      o_valid <= valid_d;
      if (state_q == DECODE) begin
        o_data        <= data_d;
        o_data_is_neg <= neg_d;
        o_error       <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_sr_display_receiver.sv
// Directed bench for sr_display_receiver: positive/negative frames, error frames,
//   backpressure with frame overwrite, reset mid-frame and shift-clock pulse handling.
module tb_sr_display_receiver;

`ifdef SR_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int PH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sr_data = 1'b0, sr_clk = 1'b0, sr_latch = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] o_data;
  logic        o_neg, o_err, o_valid;

  int checks = 0;
  int errors = 0;

  logic [39:0] f_pos, f_neg, f_bad, f_mm, f_1111, f_2222, f_ab;

  always #5 clk = ~clk;

  sr_display_receiver #(.DATA_WIDTH(16), .NUM_7_SEG_DISPLAYS(5)) dut (
    .clk(clk), .rst(rst),
    .i_sr_data(sr_data), .i_sr_clk(sr_clk), .i_sr_latch(sr_latch),
    .o_data(o_data), .o_data_is_neg(o_neg), .o_error(o_err),
    .o_valid(o_valid), .i_ready(ready)
  );

  task automatic shift_bit(input logic b);
    @(negedge clk) sr_data = b;
    repeat (PH) @(negedge clk);
    sr_clk = 1'b1;
    repeat (PH) @(negedge clk);
    sr_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) shift_bit(f[39-i]);
    repeat (PH) @(negedge clk);
  endtask

  // Raise latch, check o_valid is still low at N+LAT-1 and high at N+LAT with the expected frame.
  task automatic latch_check(input string nm, input logic chk_data, input logic [15:0] ed,
                             input logic en, input logic ee);
    @(negedge clk) sr_latch = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL %s early_valid got %b want 0", nm, o_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid got %b want 1", nm, o_valid);
    end
    if (chk_data) begin
      checks++;
      if (o_data !== ed) begin
        errors++; $display("FAIL %s data got %h want %h", nm, o_data, ed);
      end
    end
    checks++;
    if (o_neg !== en) begin
      errors++; $display("FAIL %s neg got %b want %b", nm, o_neg, en);
    end
    checks++;
    if (o_err !== ee) begin
      errors++; $display("FAIL %s err got %b want %b", nm, o_err, ee);
    end
    repeat (PH) @(negedge clk);
    sr_latch = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_data, o_neg, o_err, o_valid} !== 19'd0) begin
      errors++; $display("FAIL reset outputs got %h/%b%b%b want 0", o_data, o_neg, o_err, o_valid);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_positive;
    send_frame(f_pos, 40);
    latch_check("positive", 1'b1, 16'h0123, 1'b0, 1'b0);
  endtask

  task automatic test_negative;
    send_frame(f_neg, 40);
    latch_check("negative", 1'b1, 16'hF001, 1'b1, 1'b0);
  endtask

  task automatic test_errors;
    send_frame(f_pos, 39);
    latch_check("short39", 1'b0, 16'h0000, 1'b0, 1'b1);
    send_frame(f_bad, 40);
    latch_check("bad_glyph", 1'b1, 16'h0012, 1'b0, 1'b1);
    send_frame(f_mm, 40);
    latch_check("two_minus", 1'b1, 16'h0111, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    ready = 1'b0;
    send_frame(f_1111, 40);
    latch_check("bp_first", 1'b1, 16'h1111, 1'b0, 1'b0);
    send_frame(f_2222, 40);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h1111) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=1111", o_valid, o_data);
    end
    latch_check("bp_second", 1'b1, 16'h2222, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h2222) begin
      errors++; $display("FAIL bp_stable got v=%b d=%h want v=1 d=2222", o_valid, o_data);
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'h2222) begin
      errors++; $display("FAIL bp_accept got v=%b d=%h want v=0 d=2222", o_valid, o_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 20; i++) shift_bit(f_pos[39-i]);
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if ({o_data, o_neg, o_err, o_valid} !== 19'd0) begin
      errors++; $display("FAIL rst_mid got %h/%b%b%b want 0", o_data, o_neg, o_err, o_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(f_pos, 20);
    latch_check("after_rst_short", 1'b0, 16'h0000, 1'b0, 1'b1);
    send_frame(f_ab, 40);
    latch_check("after_rst_full", 1'b1, 16'h00AB, 1'b0, 1'b0);
  endtask

  task automatic test_glitch;
`ifdef SR_RX_GLITCH_FILTER_EN
    send_frame(f_pos, 40);
    @(negedge clk) sr_clk = 1'b1;
    @(negedge clk) sr_clk = 1'b0;
    repeat (PH) @(negedge clk);
    latch_check("glitch_filtered", 1'b1, 16'h0123, 1'b0, 1'b0);
`else
    send_frame(f_pos, 39);
    @(negedge clk) sr_data = f_pos[0];
    repeat (3) @(negedge clk);
    sr_clk = 1'b1;
    repeat (3) @(negedge clk);
    sr_clk = 1'b0;
    repeat (3) @(negedge clk);
    latch_check("pulse3_counted", 1'b1, 16'h0123, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    f_pos  = {8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F};
    f_neg  = {8'h40, 8'h71, 8'h3F, 8'h3F, 8'h06};
    f_bad  = {8'h00, 8'h00, 8'h55, 8'h06, 8'h5B};
    f_mm   = {8'h40, 8'h40, 8'h06, 8'h06, 8'h06};
    f_1111 = {8'h00, 8'h06, 8'h06, 8'h06, 8'h06};
    f_2222 = {8'h00, 8'h5B, 8'h5B, 8'h5B, 8'h5B};
    f_ab   = {8'h00, 8'h00, 8'h00, 8'h77, 8'h7C};
    test_reset();
    test_positive();
    test_negative();
    test_errors();
    test_back_to_back();
    test_reset_mid_frame();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
